// File: rtl/sseg4_tdm_capture.sv
// Receive side of the 4-digit multiplexed 7-segment bus: samples seg/dp/an,
// decodes each settled digit glyph and publishes coherent 4-digit frames.
module sseg4_tdm_capture #(
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [7:0]  status,
  output logic [3:0]  dps,
  output logic        frame_valid,
  output logic        stale
);

  localparam int unsigned SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t          state;
  logic [6:0]      seg_s1, seg_s2;
  logic            dp_s1, dp_s2;
  logic [3:0]      an_s1, an_s2;
  logic [11:0]     bus_now, bus_prev;
  logic            changed;
  logic            sel_valid;
  logic [1:0]      sel_idx;
  logic [5:0]      glyph;
  logic            cap;
  logic [3:0]      cap_bit;
  logic [SW-1:0]   stab_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [3:0]      mask;
  logic [3:0]      sh_dig [4];
  logic [1:0]      sh_st  [4];
  logic [3:0]      sh_dp;

  // Returns {status, nibble} for an active-low segment pattern.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = {2'b00, 4'h0};
      7'h79:   decode = {2'b00, 4'h1};
      7'h24:   decode = {2'b00, 4'h2};
      7'h30:   decode = {2'b00, 4'h3};
      7'h19:   decode = {2'b00, 4'h4};
      7'h12:   decode = {2'b00, 4'h5};
      7'h02:   decode = {2'b00, 4'h6};
      7'h78:   decode = {2'b00, 4'h7};
      7'h00:   decode = {2'b00, 4'h8};
      7'h10:   decode = {2'b00, 4'h9};
      7'h08:   decode = {2'b00, 4'hA};
      7'h03:   decode = {2'b00, 4'hB};
      7'h46:   decode = {2'b00, 4'hC};
      7'h21:   decode = {2'b00, 4'hD};
      7'h06:   decode = {2'b00, 4'hE};
      7'h0E:   decode = {2'b00, 4'hF};
      7'h7F:   decode = {2'b01, 4'h0};
      7'h3F:   decode = {2'b10, 4'h0};
      default: decode = {2'b11, 4'h0};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      dp_s1  <= 1'b1;
      dp_s2  <= 1'b1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      dp_s1  <= dp;
      dp_s2  <= dp_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  always_comb begin
    bus_now   = {an_s2, seg_s2, dp_s2};
    changed   = (bus_now != bus_prev);
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (an_s2)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
    glyph   = decode(seg_s2);
    cap     = (state == SETTLE) && !changed && sel_valid && (stab_cnt == SW'(STABLE - 1));
    cap_bit = 4'b0001 << sel_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus_prev    <= '1;
      stab_cnt    <= '0;
      idle_cnt    <= '0;
      mask        <= '0;
      sh_dp       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        sh_dig[i] <= '0;
        sh_st[i]  <= 2'b01;
      end
      digits      <= '0;
      status      <= 8'h55;
      dps         <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b1;
    end else begin
      bus_prev <= bus_now;

      case (state)
        IDLE: begin
          if (sel_valid) begin
            state    <= SETTLE;
            stab_cnt <= '0;
          end
        end
        SETTLE: begin
          if (changed) begin
            stab_cnt <= '0;
            if (!sel_valid) state <= IDLE;
          end else if (stab_cnt == SW'(STABLE - 1)) begin
            state <= HELD;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        HELD: begin
          if (changed) begin
            stab_cnt <= '0;
            state    <= sel_valid ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (cap) begin
        sh_dig[sel_idx] <= glyph[3:0];
        sh_st[sel_idx]  <= glyph[5:4];
        sh_dp[sel_idx]  <= ~dp_s2;
      end

      if (cap) idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;

      // A capture landing on the clearing cycle seeds the next frame's mask.
      frame_valid <= 1'b0;
      if (mask == 4'hF) begin
        for (int unsigned i = 0; i < 4; i++) begin
          digits[4*i +: 4] <= sh_dig[i];
          status[2*i +: 2] <= sh_st[i];
        end
        dps         <= sh_dp;
        frame_valid <= 1'b1;
        stale       <= 1'b0;
        mask        <= cap ? cap_bit : '0;
      end else if (idle_cnt == TW'(TIMEOUT)) begin
        stale <= 1'b1;
        mask  <= cap ? cap_bit : '0;
      end else if (cap) begin
        mask <= mask | cap_bit;
      end
    end
  end

endmodule

// File: tb/tb_sseg4_tdm_capture.sv
// Scoreboard bench for sseg4_tdm_capture: expected frames are queued as the bus is
// driven and compared when the receiver pulses frame_valid.
module tb_sseg4_tdm_capture;

  localparam int unsigned STABLE  = 4;
  localparam int unsigned TIMEOUT = 300;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  s;
    logic [3:0]  p;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [7:0]  status;
  logic [3:0]  dps;
  logic        frame_valid;
  logic        stale;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_exp   = 0;
  int unsigned nframes = 0;
  frame_t      q[$];
  frame_t      e;
  logic [27:0] held;
  logic        fv_prev;
  logic [6:0]  enc [16];
  logic [15:0] rdata;
  logic [3:0]  rdp;

  sseg4_tdm_capture #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dp(dp), .an(an),
    .digits(digits), .status(status), .dps(dps),
    .frame_valid(frame_valid), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [7:0] s, input logic [3:0] p);
    q.push_back('{d: d, s: s, p: p});
    n_exp++;
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input logic d, input int unsigned n);
    @(negedge clk);
    an  = a;
    seg = s;
    dp  = d;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_digit(input logic [1:0] idx, input logic [6:0] s, input logic d, input int unsigned n);
    drive_raw(~(4'b0001 << idx), s, d, n);
  endtask

  task automatic scan_hex(input logic [15:0] data, input logic [3:0] dpm, input int unsigned dwell);
    push_exp(data, 8'h00, dpm);
    for (int unsigned i = 0; i < 4; i++)
      drive_digit(i[1:0], enc[data[4*i +: 4]], ~dpm[i], dwell);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_drained", q.size(), 0);
  endtask

  // Output monitor: frames against the scoreboard, outputs frozen between frames.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_out", {digits, status, dps, stale, frame_valid}, {16'h0000, 8'h55, 4'h0, 1'b1, 1'b0});
      held    = {16'h0000, 8'h55, 4'h0};
      fv_prev = 1'b0;
    end else begin
      if (frame_valid) begin
        check("fv_single", fv_prev, 0);
        check("frame_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("digits", digits, e.d);
          check("status", status, e.s);
          check("dps", dps, e.p);
        end
        nframes++;
        held = {digits, status, dps};
      end else if ({digits, status, dps} != held) begin
        check("hold_outputs", {digits, status, dps}, held);
      end
      fv_prev = frame_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    enc = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    an  = 4'hF;
    seg = 7'h7F;
    dp  = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;

    // Loopback of driver data 16'h007F, 64-cycle dwells
    repeat (3) scan_hex(16'h007F, 4'h0, 64);
    drain(200);

    // All sixteen hex glyphs plus random frames
    scan_hex(16'h0123, 4'h0,    40);
    scan_hex(16'h4567, 4'b0101, 40);
    scan_hex(16'h89AB, 4'b1010, 40);
    scan_hex(16'hCDEF, 4'hF,    40);
    for (int k = 0; k < 2; k++) begin
      rdata = 16'($urandom);
      rdp   = 4'($urandom_range(0, 15));
      scan_hex(rdata, rdp, 40);
    end
    drain(200);

    // Glyph classes: blank, minus, invalid, 4 with dp
    push_exp(16'h4000, 8'b00_11_10_01, 4'b1000);
    drive_digit(2'd0, 7'h7F, 1'b1, 40);
    drive_digit(2'd1, 7'h3F, 1'b1, 40);
    drive_digit(2'd2, 7'h5A, 1'b1, 40);
    drive_digit(2'd3, 7'h19, 1'b0, 40);
    drain(200);

    // Glitch reject: 3-cycle seg chatter, 2-cycle anode dwell, 2-cycle seg change
    push_exp(16'h3A5C, 8'h00, 4'h0);
    drive_digit(2'd0, enc[1],  1'b1, 1);
    drive_digit(2'd0, enc[2],  1'b1, 1);
    drive_digit(2'd0, enc[1],  1'b1, 1);
    drive_digit(2'd0, enc[12], 1'b1, 40);
    drive_digit(2'd3, enc[14], 1'b1, 2);
    drive_digit(2'd1, enc[5],  1'b1, 40);
    drive_digit(2'd2, enc[10], 1'b1, 40);
    drive_digit(2'd2, enc[8],  1'b1, 2);
    drive_digit(2'd3, enc[3],  1'b1, 40);
    drain(200);

    // Illegal selects held mid-frame
    push_exp(16'h9182, 8'h00, 4'h0);
    drive_digit(2'd0, enc[2], 1'b1, 40);
    drive_digit(2'd1, enc[8], 1'b1, 40);
    drive_raw(4'b0011, enc[7], 1'b0, 100);
    drive_raw(4'hF,    enc[7], 1'b0, 100);
    drive_digit(2'd2, enc[1], 1'b1, 40);
    drive_digit(2'd3, enc[9], 1'b1, 40);
    drain(200);

    // Timeout: stale asserts, outputs hold, partial mask is discarded
    scan_hex(16'hBEEF, 4'b0010, 40);
    drain(200);
    check("stale_after_frame", stale, 0);
    drive_digit(2'd0, enc[1], 1'b1, 40);
    drive_digit(2'd1, enc[2], 1'b1, 40);
    drive_raw(4'hF, 7'h7F, 1'b1, TIMEOUT - 60);
    check("stale_early", stale, 0);
    drive_raw(4'hF, 7'h7F, 1'b1, 80);
    check("stale_timeout", stale, 1);
    check("held_digits", digits, 16'hBEEF);
    check("held_status", status, 8'h00);
    check("held_dps", dps, 4'b0010);
    drive_digit(2'd2, enc[10], 1'b1, 40);
    drive_digit(2'd3, enc[5],  1'b1, 40);
    push_exp(16'h5A3C, 8'h00, 4'h0);
    drive_digit(2'd0, enc[12], 1'b1, 40);
    drive_digit(2'd1, enc[3],  1'b1, 40);
    drain(200);
    check("stale_cleared", stale, 0);

    // Reset after 3 of 4 digits: partial frame discarded
    drive_digit(2'd0, enc[7], 1'b1, 40);
    drive_digit(2'd1, enc[7], 1'b1, 40);
    drive_digit(2'd2, enc[7], 1'b1, 20);
    @(posedge clk);
    #2 rst = 1'b0;
    drive_raw(4'hF, 7'h7F, 1'b1, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    drive_digit(2'd3, enc[6], 1'b1, 40);
    push_exp(16'h6123, 8'h00, 4'h0);
    drive_digit(2'd0, enc[3], 1'b1, 40);
    drive_digit(2'd1, enc[2], 1'b1, 40);
    drive_digit(2'd2, enc[1], 1'b1, 40);
    drive_digit(2'd3, enc[6], 1'b1, 40);
    drain(200);

    check("frame_count", nframes, n_exp);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
